// File: rtl/approx_err_monitor.sv
// -----------------------------------------------------------------------------
// approx_err_monitor
// Measures the error of an upstream approximate 8x8 multiplier over a run of
// N_SAMPLES accepted samples. For each accepted (x, y, z) the exact product
// x*y is compared with the approximate product z. The block accumulates:
//   sum_err      - saturating sum of |x*y - z|
//   bias         - saturating signed sum of (z - x*y)
//   max_err      - largest |x*y - z|
//   mismatch_cnt - number of samples with z != x*y
//   sat          - sticky flag, set when sum_err or bias saturated
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                begins a run (honoured in IDLE only)
//   in_valid / in_ready  sample handshake (in_ready high in RUN only)
//   x, y, z              operands and approximate product
//   res_valid/res_ready  result handshake (res_valid high in DONE)
//   sum_err, bias, max_err, mismatch_cnt, sat   run results
//   busy                 high in RUN and DRAIN
// -----------------------------------------------------------------------------
module approx_err_monitor #(
    parameter int N_SAMPLES = 256,
    parameter int SUM_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              x,
    input  logic [7:0]              y,
    input  logic [15:0]             z,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [SUM_W-1:0]        sum_err,
    output logic signed [SUM_W:0]   bias,
    output logic [15:0]             max_err,
    output logic [16:0]             mismatch_cnt,
    output logic                    sat,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [16:0] N_LAST = 17'(N_SAMPLES);

    // Extended width wide enough to hold any accumulator plus one error term
    // without wrapping, so saturation can be decided by plain comparison.
    localparam int EW = SUM_W + 19;
    localparam logic [EW-1:0]        SUM_MAX = {{(EW-SUM_W){1'b0}}, {SUM_W{1'b1}}};
    localparam logic signed [EW-1:0] B_POS   = $signed(SUM_MAX);
    localparam logic signed [EW-1:0] B_NEG   = -B_POS;

    logic [1:0]              r_state;
    logic [16:0]             r_cnt;
    logic                    r_drain;
    logic                    r_s1_valid;
    logic [15:0]             r_prod;
    logic [15:0]             r_z;
    logic [SUM_W-1:0]        r_sum;
    logic signed [SUM_W:0]   r_bias;
    logic [15:0]             r_max;
    logic [16:0]             r_mis;
    logic                    r_sat;

    logic                    w_accept;
    logic [16:0]             w_cnt_inc;
    logic signed [16:0]      w_diff;
    logic [16:0]             w_abs;
    logic [EW-1:0]           w_sum_ext;
    logic signed [EW-1:0]    w_bias_ext;
    logic [SUM_W-1:0]        w_sum_new;
    logic signed [SUM_W:0]   w_bias_new;
    logic                    w_sat_hit;

    assign w_accept  = in_valid && (r_state == S_RUN);
    assign w_cnt_inc = r_cnt + 17'd1;

    always_comb begin
        w_diff     = $signed({1'b0, r_z}) - $signed({1'b0, r_prod});
        w_abs      = w_diff[16] ? 17'(-w_diff) : 17'(w_diff);
        w_sum_ext  = EW'(r_sum) + EW'(w_abs);
        w_bias_ext = EW'(r_bias) + EW'(w_diff);
        w_sat_hit  = 1'b0;
        w_sum_new  = w_sum_ext[SUM_W-1:0];
        w_bias_new = w_bias_ext[SUM_W:0];
        if (w_sum_ext > SUM_MAX) begin
            w_sum_new = SUM_MAX[SUM_W-1:0];
            w_sat_hit = 1'b1;
        end
        if (w_bias_ext > B_POS) begin
            w_bias_new = B_POS[SUM_W:0];
            w_sat_hit  = 1'b1;
        end else if (w_bias_ext < B_NEG) begin
            w_bias_new = B_NEG[SUM_W:0];
            w_sat_hit  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_drain    <= 1'b0;
            r_s1_valid <= 1'b0;
            r_prod     <= '0;
            r_z        <= '0;
            r_sum      <= '0;
            r_bias     <= '0;
            r_max      <= '0;
            r_mis      <= '0;
            r_sat      <= 1'b0;
        end else begin
            // Stage 1: capture exact product and approximate product.
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_prod <= {8'd0, x} * {8'd0, y};
                r_z    <= z;
            end

            // Stage 2: fold the captured sample into the accumulators.
            if (r_s1_valid) begin
                r_sum  <= w_sum_new;
                r_bias <= w_bias_new;
                if (w_abs > {1'b0, r_max}) begin
                    r_max <= w_abs[15:0];
                end
                if (w_diff != '0) begin
                    r_mis <= r_mis + 17'd1;
                end
                if (w_sat_hit) begin
                    r_sat <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_bias  <= '0;
                        r_max   <= '0;
                        r_mis   <= '0;
                        r_sat   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == N_LAST) begin
                            r_state <= S_DRAIN;
                            r_drain <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Two cycles: lets the last sample clear both stages.
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready     = (r_state == S_RUN);
    assign res_valid    = (r_state == S_DONE);
    assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign sum_err      = r_sum;
    assign bias         = r_bias;
    assign max_err      = r_max;
    assign mismatch_cnt = r_mis;
    assign sat          = r_sat;

endmodule

// File: tb/tb_approx_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_approx_err_monitor
// Directed bench for approx_err_monitor. Three instances share clock, reset,
// operands and res_ready; each has its own start/in_valid:
//   A: N_SAMPLES=4, SUM_W=32   B: N_SAMPLES=2, SUM_W=10   C: N_SAMPLES=1
// -----------------------------------------------------------------------------
module tb_approx_err_monitor;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0]  x, y;
    logic [15:0] z;
    logic res_ready;

    logic a_start, a_in_valid, a_in_ready, a_res_valid, a_sat, a_busy;
    logic [31:0] a_sum;
    logic signed [32:0] a_bias;
    logic [15:0] a_max;
    logic [16:0] a_mis;

    logic b_start, b_in_valid, b_in_ready, b_res_valid, b_sat, b_busy;
    logic [9:0] b_sum;
    logic signed [10:0] b_bias;
    logic [15:0] b_max;
    logic [16:0] b_mis;

    logic c_start, c_in_valid, c_in_ready, c_res_valid, c_sat, c_busy;
    logic [31:0] c_sum;
    logic signed [32:0] c_bias;
    logic [15:0] c_max;
    logic [16:0] c_mis;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    approx_err_monitor #(.N_SAMPLES(4), .SUM_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .x(x), .y(y), .z(z), .res_valid(a_res_valid),
        .res_ready(res_ready), .sum_err(a_sum), .bias(a_bias), .max_err(a_max),
        .mismatch_cnt(a_mis), .sat(a_sat), .busy(a_busy)
    );

    approx_err_monitor #(.N_SAMPLES(2), .SUM_W(10)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .x(x), .y(y), .z(z), .res_valid(b_res_valid),
        .res_ready(res_ready), .sum_err(b_sum), .bias(b_bias), .max_err(b_max),
        .mismatch_cnt(b_mis), .sat(b_sat), .busy(b_busy)
    );

    approx_err_monitor #(.N_SAMPLES(1), .SUM_W(32)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .x(x), .y(y), .z(z), .res_valid(c_res_valid),
        .res_ready(res_ready), .sum_err(c_sum), .bias(c_bias), .max_err(c_max),
        .mismatch_cnt(c_mis), .sat(c_sat), .busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample into A for one cycle.
    task automatic send_a(input logic [7:0] xi, input logic [7:0] yi, input logic [15:0] zi);
        x = xi; y = yi; z = zi; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b exp 0", a_in_ready); end
        n_checks++; if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got %0b exp 0", a_res_valid); end
        n_checks++; if (a_sum !== 32'd0) begin n_fail++; $display("FAIL rst_sum got %0d exp 0", a_sum); end

        // No acceptance without a start pulse.
        x = 8'd9; y = 8'd9; z = 16'd0; a_in_valid = 1'b1;
        repeat (3) tick();
        a_in_valid = 1'b0;
        n_checks++; if (a_in_ready !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL nostart_idle got rdy=%0b busy=%0b exp 0/0", a_in_ready, a_busy); end

        // Reset asserted mid-run.
        a_start = 1'b1; tick(); a_start = 1'b0;
        n_checks++; if (a_in_ready !== 1'b1 || a_busy !== 1'b1) begin n_fail++; $display("FAIL run_entry got rdy=%0b busy=%0b exp 1/1", a_in_ready, a_busy); end
        send_a(8'd9, 8'd9, 16'd0);
        send_a(8'd9, 8'd9, 16'd0);
        tick();
        n_checks++; if (a_sum !== 32'd162 || a_mis !== 17'd2) begin n_fail++; $display("FAIL midrun_acc got sum=%0d mis=%0d exp 162/2", a_sum, a_mis); end
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        n_checks++; if (a_in_ready !== 1'b0 || a_busy !== 1'b0 || a_res_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_ctrl got rdy=%0b busy=%0b rv=%0b exp 0/0/0", a_in_ready, a_busy, a_res_valid); end
        n_checks++; if (a_sum !== 32'd0 || a_bias !== 33'sd0 || a_max !== 16'd0 || a_mis !== 17'd0 || a_sat !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_res got sum=%0d bias=%0d max=%0d mis=%0d sat=%0b exp all 0", a_sum, a_bias, a_max, a_mis, a_sat); end
        tick();
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got %0b exp 0", a_in_ready); end
    endtask

    task automatic test_exact();
        int n;
        a_start = 1'b1; tick(); a_start = 1'b0;
        send_a(8'd3, 8'd5, 16'd15);
        send_a(8'd7, 8'd9, 16'd63);
        send_a(8'd0, 8'd200, 16'd0);
        send_a(8'd255, 8'd1, 16'd255);
        n_checks++; if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL exact_drain got rdy=%0b busy=%0b exp 0/1", a_in_ready, a_busy); end
        n = 0;
        while (a_res_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (a_res_valid !== 1'b1) begin n_fail++; $display("FAIL exact_res_valid got %0b exp 1 (timeout)", a_res_valid); end
        n_checks++; if (a_sum !== 32'd0 || a_bias !== 33'sd0 || a_max !== 16'd0 || a_mis !== 17'd0 || a_sat !== 1'b0) begin n_fail++; $display("FAIL exact_results got sum=%0d bias=%0d max=%0d mis=%0d sat=%0b exp all 0", a_sum, a_bias, a_max, a_mis, a_sat); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        n_checks++; if (a_res_valid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL exact_release got rv=%0b busy=%0b exp 0/0", a_res_valid, a_busy); end
    endtask

    task automatic test_mismatch();
        int n;
        a_start = 1'b1; tick(); a_start = 1'b0;
        send_a(8'd255, 8'd255, 16'd64512);
        tick();
        send_a(8'd16, 8'd16, 16'd260);
        tick(); tick();
        send_a(8'd0, 8'd7, 16'd0);
        tick();
        send_a(8'd3, 8'd5, 16'd15);
        // 4th acceptance edge just passed; DONE must be visible after 2 more edges.
        n = 0;
        while (a_res_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (n != 2) begin n_fail++; $display("FAIL mm_latency got %0d exp 2 edges after acceptance edge", n); end
        n_checks++; if (a_sum !== 32'd517) begin n_fail++; $display("FAIL mm_sum got %0d exp 517", a_sum); end
        n_checks++; if (a_bias !== -33'sd509) begin n_fail++; $display("FAIL mm_bias got %0d exp -509", a_bias); end
        n_checks++; if (a_max !== 16'd513) begin n_fail++; $display("FAIL mm_max got %0d exp 513", a_max); end
        n_checks++; if (a_mis !== 17'd2 || a_sat !== 1'b0) begin n_fail++; $display("FAIL mm_mis_sat got mis=%0d sat=%0b exp 2/0", a_mis, a_sat); end
    endtask

    task automatic test_backpressure();
        a_start = 1'b1; a_in_valid = 1'b1; res_ready = 1'b0;
        x = 8'd200; y = 8'd200; z = 16'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (a_res_valid !== 1'b1 || a_in_ready !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL bp_ctrl[%0d] got rv=%0b rdy=%0b busy=%0b exp 1/0/0", i, a_res_valid, a_in_ready, a_busy); end
            n_checks++; if (a_sum !== 32'd517 || a_bias !== -33'sd509 || a_max !== 16'd513 || a_mis !== 17'd2) begin n_fail++; $display("FAIL bp_hold[%0d] got sum=%0d bias=%0d max=%0d mis=%0d exp 517/-509/513/2", i, a_sum, a_bias, a_max, a_mis); end
        end
        a_start = 1'b0; a_in_valid = 1'b0;
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        n_checks++; if (a_res_valid !== 1'b0 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release got rv=%0b rdy=%0b exp 0/0", a_res_valid, a_in_ready); end
        tick();
        n_checks++; if (a_sum !== 32'd517 || a_max !== 16'd513) begin n_fail++; $display("FAIL idle_retain got sum=%0d max=%0d exp 517/513", a_sum, a_max); end
    endtask

    task automatic test_saturation();
        int n;
        b_start = 1'b1; tick(); b_start = 1'b0;
        x = 8'd255; y = 8'd255; z = 16'd64512; b_in_valid = 1'b1;
        tick(); tick();
        b_in_valid = 1'b0;
        n = 0;
        while (b_res_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (b_res_valid !== 1'b1) begin n_fail++; $display("FAIL sat_res_valid got %0b exp 1 (timeout)", b_res_valid); end
        n_checks++; if (b_sum !== 10'd1023) begin n_fail++; $display("FAIL sat_sum got %0d exp 1023", b_sum); end
        n_checks++; if (b_bias !== -11'sd1023) begin n_fail++; $display("FAIL sat_bias got %0d exp -1023", b_bias); end
        n_checks++; if (b_max !== 16'd513 || b_sat !== 1'b1 || b_mis !== 17'd2) begin n_fail++; $display("FAIL sat_flags got max=%0d sat=%0b mis=%0d exp 513/1/2", b_max, b_sat, b_mis); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        b_start = 1'b1; tick(); b_start = 1'b0;
        n_checks++; if (b_sat !== 1'b0 || b_sum !== 10'd0 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_clear got sat=%0b sum=%0d rdy=%0b exp 0/0/1", b_sat, b_sum, b_in_ready); end
    endtask

    task automatic test_single();
        int n;
        c_start = 1'b1; tick(); c_start = 1'b0;
        x = 8'd1; y = 8'd1; z = 16'd0; c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        n_checks++; if (c_in_ready !== 1'b0 || c_busy !== 1'b1) begin n_fail++; $display("FAIL single_stop got rdy=%0b busy=%0b exp 0/1", c_in_ready, c_busy); end
        n = 0;
        while (c_res_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (n != 2) begin n_fail++; $display("FAIL single_latency got %0d exp 2", n); end
        n_checks++; if (c_sum !== 32'd1 || c_bias !== -33'sd1 || c_mis !== 17'd1 || c_max !== 16'd1) begin n_fail++; $display("FAIL single_results got sum=%0d bias=%0d mis=%0d max=%0d exp 1/-1/1/1", c_sum, c_bias, c_mis, c_max); end
    endtask

    initial begin
        rst_n = 1'b0; res_ready = 1'b0;
        x = '0; y = '0; z = '0;
        a_start = 1'b0; a_in_valid = 1'b0;
        b_start = 1'b0; b_in_valid = 1'b0;
        c_start = 1'b0; c_in_valid = 1'b0;
        test_reset();
        test_exact();
        test_mismatch();
        test_backpressure();
        test_saturation();
        test_single();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
